jtmx5k_snd_cmd: RTL

Main-CPU-side sound command transmitter for the MX5000 core. It captures command bytes written by the main CPU and queues them in a small FIFO. It presents each byte on `snd_latch` and raises a fixed-width `snd_irq` pulse, which the sound board edge-detects to interrupt its Z80. It then holds the byte until the sound CPU acknowledges the read, so back-to-back commands are never overwritten.

---
 rtl/jtmx5k_snd_cmd.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jtmx5k_snd_cmd.sv
// Sound command transmitter: queues main-CPU command bytes and presents them one
// at a time to the sound board with a fixed-width IRQ pulse, waiting for an ack.
module jtmx5k_snd_cmd #(
  parameter int AW      = 2,
  parameter int IRQ_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       latch_cs,
  input  logic       irq_cs,
  input  logic       wr_n,
  input  logic [7:0] din,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  logic [7:0]    stage_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          acked_reg, acked_next;
  logic [7:0]    latch_reg, latch_next;
  logic          irq_reg, irq_next;

  logic       we, push, pop, push_ok, fifo_full, fifo_empty;
  logic [7:0] push_data;

  assign we         = cpu_cen & ~wr_n;
  assign push       = we & irq_cs;
  assign push_data  = latch_cs ? din : stage_reg;
  assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = (state_reg == IDLE) & ~fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign push_ok    = push & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg  <= 8'h00;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (we & latch_cs) stage_reg <= din;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push & ~push_ok) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'h00;
      acked_reg <= 1'b0;
      latch_reg <= 8'h00;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acked_reg <= acked_next;
      latch_reg <= latch_next;
      irq_reg   <= irq_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acked_next = acked_reg;
    latch_next = latch_reg;
    irq_next   = irq_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          latch_next = mem[rd_ptr_reg];
          irq_next   = 1'b1;
          cnt_next   = 8'(IRQ_LEN - 1);
          acked_next = 1'b0;
          state_next = PULSE;
        end
      end
      PULSE: begin
        // An early ack is remembered; the pulse still runs to full length
        if (snd_ack) acked_next = 1'b1;
        if (cnt_reg == 8'h00) begin
          irq_next   = 1'b0;
          state_next = WAIT;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      WAIT: begin
        irq_next = 1'b0;
        if (snd_ack | acked_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign snd_latch = latch_reg;
  assign snd_irq   = irq_reg;
  assign busy      = (state_reg != IDLE) | ~fifo_empty;
  assign full      = fifo_full;
  assign ovf       = ovf_reg;

endmodule
